ccd_sensor_emulator: RTL and testbench

//  Cycle-accurate stand-in for the camera head: generates 10-bit pixel data with FVAL/LVAL

---
 rtl/ccd_sensor_emulator_if.sv | 23 ++
 rtl/ccd_sensor_emulator.sv | 168 ++++++++++++++++
 tb/tb_ccd_sensor_emulator.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccd_sensor_emulator_if.sv
// Control inputs and framed pixel bus of the CCD sensor emulator.
interface ccd_sensor_emulator_if #(
    parameter int DATA_W = 10
);
    logic              iEN;
    logic [1:0]        iPATTERN;
    logic [DATA_W-1:0] iCONST;
    logic [DATA_W-1:0] oDATA;
    logic              oFVAL;
    logic              oLVAL;
    logic [31:0]       oFrame_Cont;
    logic              oBusy;

    modport master (
        input  iEN, iPATTERN, iCONST,
        output oDATA, oFVAL, oLVAL, oFrame_Cont, oBusy
    );

    modport slave (
        output iEN, iPATTERN, iCONST,
        input  oDATA, oFVAL, oLVAL, oFrame_Cont, oBusy
    );
endinterface

// File: rtl/ccd_sensor_emulator.sv
// Pixel-clock stand-in for the CCD head: test patterns with FVAL/LVAL framing.
module ccd_sensor_emulator #(
    parameter int H_ACTIVE = 1280,
    parameter int H_BLANK  = 64,
    parameter int V_ACTIVE = 1024,
    parameter int V_BLANK  = 512,
    parameter int FV_PRE   = 8,
    parameter int FV_POST  = 8,
    parameter int DATA_W   = 10
) (
    input logic                   iCLK,
    input logic                   iRST,
    ccd_sensor_emulator_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_VBLANK,
        S_FV_PRE,
        S_LINE,
        S_HBLANK,
        S_FV_POST
    } state_t;

    localparam logic [31:0] HA_LAST = 32'(H_ACTIVE - 1);
    localparam logic [31:0] HB_LAST = 32'(H_BLANK - 1);
    localparam logic [31:0] VA_LAST = 32'(V_ACTIVE - 1);
    localparam logic [31:0] VB_LAST = 32'(V_BLANK - 1);
    localparam logic [31:0] FP_LAST = 32'(FV_PRE - 1);
    localparam logic [31:0] FQ_LAST = 32'(FV_POST - 1);

    state_t            state;
    logic [31:0]       cnt;
    logic [31:0]       x;
    logic [31:0]       y;
    logic [31:0]       x_nxt;
    logic [1:0]        pat_q;
    logic [DATA_W-1:0] const_q;
    logic [DATA_W-1:0] data_q;
    logic              fval_q;
    logic              lval_q;
    logic              busy_q;
    logic [31:0]       frames_q;

    assign x_nxt = x + 32'd1;

    // Pattern select is the copy latched at the end of VBLANK.
    function automatic logic [DATA_W-1:0] pixel(
        input logic [DATA_W-1:0] px,
        input logic [DATA_W-1:0] py
    );
        logic [DATA_W-1:0] v;
        v = '0;
        unique case (pat_q)
            2'd0:    v = px;
            2'd1:    v = py;
            2'd2:    v = (px[3] ^ py[3]) ? '1 : '0;
            default: v = const_q;
        endcase
        return v;
    endfunction

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            x        <= '0;
            y        <= '0;
            pat_q    <= '0;
            const_q  <= '0;
            data_q   <= '0;
            fval_q   <= 1'b0;
            lval_q   <= 1'b0;
            busy_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.iEN) begin
                        state  <= S_VBLANK;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                S_VBLANK: begin
                    if (cnt == VB_LAST) begin
                        cnt     <= '0;
                        pat_q   <= bus.iPATTERN;
                        const_q <= bus.iCONST;
                        if (bus.iEN) begin
                            state  <= S_FV_PRE;
                            fval_q <= 1'b1;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_FV_PRE: begin
                    if (cnt == FP_LAST) begin
                        cnt    <= '0;
                        x      <= '0;
                        y      <= '0;
                        state  <= S_LINE;
                        lval_q <= 1'b1;
                        data_q <= pixel('0, '0);
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_LINE: begin
                    if (x == HA_LAST) begin
                        x      <= '0;
                        cnt    <= '0;
                        lval_q <= 1'b0;
                        data_q <= '0;
                        if (y == VA_LAST) begin
                            state <= S_FV_POST;
                        end else begin
                            y     <= y + 32'd1;
                            state <= S_HBLANK;
                        end
                    end else begin
                        x      <= x_nxt;
                        data_q <= pixel(x_nxt[DATA_W-1:0], y[DATA_W-1:0]);
                    end
                end
                S_HBLANK: begin
                    if (cnt == HB_LAST) begin
                        cnt    <= '0;
                        state  <= S_LINE;
                        lval_q <= 1'b1;
                        data_q <= pixel('0, y[DATA_W-1:0]);
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_FV_POST: begin
                    if (cnt == FQ_LAST) begin
                        cnt      <= '0;
                        y        <= '0;
                        fval_q   <= 1'b0;
                        frames_q <= frames_q + 32'd1;
                        if (bus.iEN) begin
                            state <= S_VBLANK;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oDATA       = data_q;
    assign bus.oFVAL       = fval_q;
    assign bus.oLVAL       = lval_q;
    assign bus.oFrame_Cont = frames_q;
    assign bus.oBusy       = busy_q;
endmodule

// File: tb/tb_ccd_sensor_emulator.sv
// Scoreboard bench: expected pixels queued by stimulus, popped by monitors.
module tb_ccd_sensor_emulator;
    localparam int HA = 8;
    localparam int HB = 4;
    localparam int VA = 4;
    localparam int VB = 6;
    localparam int FP = 2;
    localparam int FQ = 2;
    localparam int FRAME = VB + FP + VA * HA + (VA - 1) * HB + FQ;
    localparam int FHIGH = FRAME - VB;
    localparam int BW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ccd_sensor_emulator_if #(.DATA_W(10)) ifa ();
    ccd_sensor_emulator_if #(.DATA_W(10)) ifb ();

    ccd_sensor_emulator #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
        .FV_PRE(FP), .FV_POST(FQ), .DATA_W(10)
    ) dut_a (
        .iCLK(clk), .iRST(rst), .bus(ifa.master)
    );

    ccd_sensor_emulator #(
        .H_ACTIVE(BW), .H_BLANK(HB), .V_ACTIVE(BW), .V_BLANK(VB),
        .FV_PRE(FP), .FV_POST(FQ), .DATA_W(10)
    ) dut_b (
        .iCLK(clk), .iRST(rst), .bus(ifb.master)
    );

    int n_chk = 0;
    int n_pass = 0;
    logic [9:0] qa[$];
    logic [9:0] qb[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [9:0] exp_pix(input int pat, input logic [9:0] cv,
                                           input int x, input int y);
        logic [9:0] v;
        case (pat)
            0:       v = 10'(x);
            1:       v = 10'(y);
            2:       v = (((x / 8) % 2) != ((y / 8) % 2)) ? 10'h3FF : 10'h000;
            default: v = cv;
        endcase
        return v;
    endfunction

    task automatic push_a(input int pat, input logic [9:0] cv);
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                qa.push_back(exp_pix(pat, cv, x, y));
    endtask

    task automatic wait_cnt(input int t);
        int n;
        n = 0;
        while (ifa.oFrame_Cont != t && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_cont", ifa.oFrame_Cont, t);
    endtask

    task automatic wait_lrise();
        int n;
        n = 0;
        while (ifa.oLVAL && n < 500) begin @(negedge clk); n++; end
        while (!ifa.oLVAL && n < 500) begin @(negedge clk); n++; end
        chk("lval_rise", ifa.oLVAL, 1);
    endtask

    task automatic wait_frise();
        int n;
        n = 0;
        while (ifa.oFVAL && n < 500) begin @(negedge clk); n++; end
        while (!ifa.oFVAL && n < 500) begin @(negedge clk); n++; end
        chk("fval_rise", ifa.oFVAL, 1);
    endtask

    // Monitor A: pixel scoreboard plus frame/line timing.
    initial begin
        logic pf, pl, have_rise, busy_cont;
        int per, frun, lrun, lgap, npul;
        pf = 0; pl = 0; have_rise = 0; busy_cont = 0;
        per = 0; frun = 0; lrun = 0; lgap = 0; npul = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pf = 0; pl = 0; have_rise = 0; busy_cont = 0;
                per = 0; frun = 0; lrun = 0; lgap = 0; npul = 0;
            end else begin
                if (ifa.oLVAL) begin
                    chk("lval_in_fval", ifa.oFVAL, 1);
                    if (qa.size() == 0) chk("pix_a_unexpected", qa.size(), 1);
                    else chk("pix_a", ifa.oDATA, qa.pop_front());
                end else begin
                    chk("data_zero_a", ifa.oDATA, 0);
                end
                if (have_rise) per++;
                if (!ifa.oBusy) busy_cont = 0;
                if (ifa.oFVAL && !pf) begin
                    if (have_rise && busy_cont) chk("frame_period", per, FRAME);
                    have_rise = 1; busy_cont = 1;
                    per = 0; frun = 1; npul = 0;
                end else if (ifa.oFVAL) begin
                    frun++;
                end
                if (!ifa.oFVAL && pf) begin
                    chk("fval_high", frun, FHIGH);
                    chk("lval_pulses", npul, VA);
                    chk("fv_post", lgap, FQ);
                end
                if (ifa.oLVAL && !pl) begin
                    if (npul == 0) chk("fv_pre", frun - 1, FP);
                    else chk("lval_gap", lgap, HB);
                    npul++;
                    lrun = 1;
                end else if (ifa.oLVAL) begin
                    lrun++;
                end
                if (!ifa.oLVAL && pl) begin
                    chk("lval_width", lrun, HA);
                    lgap = 1;
                end else if (!ifa.oLVAL && ifa.oFVAL) begin
                    lgap++;
                end
                pf = ifa.oFVAL;
                pl = ifa.oLVAL;
            end
        end
    end

    // Monitor B: checkerboard pixels on the 16x16 instance.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && ifb.oLVAL) begin
                if (qb.size() == 0) chk("pix_b_unexpected", qb.size(), 1);
                else chk("pix_b", ifb.oDATA, qb.pop_front());
            end
        end
    end

    // Stimulus B: one checkerboard frame, then stop.
    initial begin
        int n;
        ifb.iEN = 0;
        ifb.iPATTERN = 2'd2;
        ifb.iCONST = '0;
        @(negedge clk);
        while (rst) @(negedge clk);
        for (int y = 0; y < BW; y++)
            for (int x = 0; x < BW; x++)
                qb.push_back(exp_pix(2, 10'h0, x, y));
        ifb.iEN = 1;
        n = 0;
        while (!ifb.oFVAL && n < 100) begin @(negedge clk); n++; end
        chk("b_fval", ifb.oFVAL, 1);
        ifb.iEN = 0;
        n = 0;
        while (ifb.oFrame_Cont != 1 && n < 1000) begin @(negedge clk); n++; end
        chk("b_frames", ifb.oFrame_Cont, 1);
        repeat (10) @(negedge clk);
        chk("b_busy_idle", ifb.oBusy, 0);
        chk("b_qb_empty", qb.size(), 0);
    end

    // Stimulus A: directed frame sequence.
    initial begin
        int n;
        ifa.iEN = 0;
        ifa.iPATTERN = 2'd0;
        ifa.iCONST = '0;
        repeat (3) @(negedge clk);
        chk("rst_fval", ifa.oFVAL, 0);
        chk("rst_lval", ifa.oLVAL, 0);
        chk("rst_data", ifa.oDATA, 0);
        chk("rst_frames", ifa.oFrame_Cont, 0);
        chk("rst_busy", ifa.oBusy, 0);
        rst = 0;
        @(negedge clk);

        push_a(0, 10'h0);
        ifa.iEN = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ifa.oFVAL && n < 100);
        chk("fval_latency", n, 7);
        chk("busy_run", ifa.oBusy, 1);
        wait_cnt(1);

        ifa.iPATTERN = 2'd1;
        repeat (3) push_a(1, 10'h0);
        wait_cnt(4);

        ifa.iPATTERN = 2'd3;
        ifa.iCONST = 10'h2AA;
        push_a(3, 10'h2AA);
        wait_lrise();
        ifa.iPATTERN = 2'd0;
        ifa.iCONST = 10'h155;
        push_a(0, 10'h0);
        wait_cnt(5);
        wait_frise();
        ifa.iPATTERN = 2'd3;
        push_a(3, 10'h155);
        wait_cnt(6);

        wait_lrise();
        ifa.iEN = 0;
        wait_cnt(7);
        chk("idle_busy", ifa.oBusy, 0);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifa.oFVAL) n++;
        end
        chk("idle_no_fval", n, 0);
        chk("idle_frames", ifa.oFrame_Cont, 7);
        chk("qa_empty_pre_rst", qa.size(), 0);
        chk("b_frames_pre_rst", ifb.oFrame_Cont, 1);

        ifa.iPATTERN = 2'd0;
        push_a(0, 10'h0);
        ifa.iEN = 1;
        wait_lrise();
        wait_lrise();
        wait_lrise();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1;
        #1;
        chk("mid_rst_fval", ifa.oFVAL, 0);
        chk("mid_rst_lval", ifa.oLVAL, 0);
        chk("mid_rst_data", ifa.oDATA, 0);
        chk("mid_rst_frames", ifa.oFrame_Cont, 0);
        chk("mid_rst_busy", ifa.oBusy, 0);
        qa.delete();
        @(negedge clk);
        push_a(0, 10'h0);
        #1 rst = 0;
        wait_cnt(1);
        ifa.iEN = 0;
        repeat (60) @(negedge clk);
        chk("qa_empty", qa.size(), 0);
        chk("end_busy", ifa.oBusy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
